// File: rtl/chime_pkg.sv
// Shared definitions for the chime sequencer: state codes, priority encodings
// and per-phase tick counts.
package chime_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_P1_ON  = 3'd1;
  localparam state_t ST_P1_OFF = 3'd2;
  localparam state_t ST_P2_ON  = 3'd3;
  localparam state_t ST_P2_OFF = 3'd4;
  localparam state_t ST_HOLD   = 3'd5;

  typedef logic [1:0] pri_t;

  localparam pri_t PRI_NONE = 2'b00;
  localparam pri_t PRI_ONE  = 2'b01;
  localparam pri_t PRI_TWO  = 2'b10;

  localparam int PHASE_W = 2;

  localparam logic [PHASE_W-1:0] P1_ON_TICKS  = 2'd2;
  localparam logic [PHASE_W-1:0] P1_OFF_TICKS = 2'd2;
  localparam logic [PHASE_W-1:0] P2_ON_TICKS  = 2'd1;
  localparam logic [PHASE_W-1:0] P2_OFF_TICKS = 2'd3;

  // Index of the final tick of a timed phase; untimed states report 0.
  function automatic logic [PHASE_W-1:0] phase_last(input state_t s);
    case (s)
      ST_P1_ON:  phase_last = P1_ON_TICKS - 2'd1;
      ST_P1_OFF: phase_last = P1_OFF_TICKS - 2'd1;
      ST_P2_ON:  phase_last = P2_ON_TICKS - 2'd1;
      ST_P2_OFF: phase_last = P2_OFF_TICKS - 2'd1;
      default:   phase_last = '0;
    endcase
  endfunction

endpackage

// File: rtl/chime_tick_gen.sv
// Pattern-tick prescaler: TICK pulses for one cycle every TICK_DIV cycles,
// restarting from zero whenever CLR is asserted.
module chime_tick_gen #(
  parameter int TICK_DIV = 5000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  output logic TICK
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (CLR || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign TICK = (cnt == CNT_LAST);

endmodule

// File: rtl/chime_sequencer.sv
// Two-priority warning chime sequencer with PRI2 burst limit and mute.
// Define CHIME_ACK_EN to let an ACK rising edge mute an active PRI2 pattern.
module chime_sequencer
  import chime_pkg::*;
#(
  parameter int TICK_DIV = 5000000,
  parameter int P2_REPS  = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       KEY,
  input  logic       WARN_PRI1,
  input  logic       WARN_PRI2,
  input  logic       ACK,
  output logic       CHIME_OUT,
  output logic [1:0] ACTIVE_PRI,
  output logic       MUTED
);

  localparam int BURST_W = $clog2(P2_REPS + 1);
  localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(P2_REPS);

`ifdef CHIME_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  state_t               state;
  state_t               nxt;
  logic [PHASE_W-1:0]   phase;
  logic [BURST_W-1:0]   burst;
  logic [BURST_W-1:0]   burst_nxt;
  logic [BURST_W-1:0]   burst_inc;
  logic                 ack_q;
  logic                 ack_rise;
  logic                 tick;
  logic                 clr;
  logic                 p_end;

  chime_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .CLK  (CLK),
    .RST  (RST),
    .CLR  (clr),
    .TICK (tick)
  );

  assign ack_rise  = ACK_EN & ACK & ~ack_q;
  assign burst_inc = burst + 1'b1;
  assign p_end     = tick && (phase == phase_last(state));
  assign clr       = (nxt != state);

  always_comb begin
    nxt       = state;
    burst_nxt = burst;
    if (!KEY || (!WARN_PRI1 && !WARN_PRI2)) begin
      nxt       = ST_IDLE;
      burst_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (WARN_PRI1) begin
            nxt = ST_P1_ON;
          end else begin
            nxt       = ST_P2_ON;
            burst_nxt = '0;
          end
        end
        ST_P1_ON, ST_P1_OFF: begin
          // Dropping back to PRI2 always starts a fresh burst budget.
          if (!WARN_PRI1) begin
            nxt       = ST_P2_ON;
            burst_nxt = '0;
          end else if (p_end) begin
            nxt = (state == ST_P1_ON) ? ST_P1_OFF : ST_P1_ON;
          end
        end
        ST_P2_ON: begin
          if (WARN_PRI1)    nxt = ST_P1_ON;
          else if (ack_rise) nxt = ST_HOLD;
          else if (p_end)   nxt = ST_P2_OFF;
        end
        ST_P2_OFF: begin
          if (WARN_PRI1) begin
            nxt = ST_P1_ON;
          end else if (ack_rise) begin
            nxt = ST_HOLD;
          end else if (p_end) begin
            burst_nxt = burst_inc;
            nxt       = (burst_inc == BURST_LIMIT) ? ST_HOLD : ST_P2_ON;
          end
        end
        ST_HOLD: begin
          if (WARN_PRI1) nxt = ST_P1_ON;
        end
        default: nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      phase <= '0;
      burst <= '0;
      ack_q <= 1'b0;
    end else begin
      state <= nxt;
      burst <= burst_nxt;
      ack_q <= ACK;
      if (clr || p_end) begin
        phase <= '0;
      end else if (tick) begin
        phase <= phase + 1'b1;
      end
    end
  end

  assign CHIME_OUT = (state == ST_P1_ON) || (state == ST_P2_ON);
  assign MUTED     = (state == ST_HOLD);

  always_comb begin
    ACTIVE_PRI = PRI_NONE;
    case (state)
      ST_P1_ON, ST_P1_OFF:         ACTIVE_PRI = PRI_ONE;
      ST_P2_ON, ST_P2_OFF, ST_HOLD: ACTIVE_PRI = PRI_TWO;
      default:                     ACTIVE_PRI = PRI_NONE;
    endcase
  end

endmodule

// File: tb/tb_chime_sequencer.sv
// Self-checking bench for chime_sequencer (TICK_DIV=4, P2_REPS=3); expectations
// for the ACK mute follow whether CHIME_ACK_EN is defined.
`timescale 1ns/1ps
module tb_chime_sequencer;

  localparam int TICK_DIV = 4;
  localparam int P2_REPS  = 3;

  localparam logic [1:0] NONE = 2'b00;
  localparam logic [1:0] P1   = 2'b01;
  localparam logic [1:0] P2   = 2'b10;

`ifdef CHIME_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       KEY = 1'b0;
  logic       WARN_PRI1 = 1'b0;
  logic       WARN_PRI2 = 1'b0;
  logic       ACK = 1'b0;
  logic       CHIME_OUT;
  logic [1:0] ACTIVE_PRI;
  logic       MUTED;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         tag;
    logic       c;
    logic [1:0] p;
    logic       m;
  } exp_t;

  typedef struct {
    logic       k;
    logic       w1;
    logic       w2;
    logic       ak;
    int         n;
    logic       c;
    logic [1:0] p;
    logic       m;
    int         tag;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];

  chime_sequencer #(
    .TICK_DIV (TICK_DIV),
    .P2_REPS  (P2_REPS)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .KEY        (KEY),
    .WARN_PRI1  (WARN_PRI1),
    .WARN_PRI2  (WARN_PRI2),
    .ACK        (ACK),
    .CHIME_OUT  (CHIME_OUT),
    .ACTIVE_PRI (ACTIVE_PRI),
    .MUTED      (MUTED)
  );

  always #5 CLK = ~CLK;

  task automatic compare(input int tag, input logic c, input logic [1:0] p, input logic m);
    tests++;
    if (CHIME_OUT !== c || ACTIVE_PRI !== p || MUTED !== m) begin
      fails++;
      $display("FAIL seg%0d t=%0t: got chime=%b pri=%b muted=%b, want chime=%b pri=%b muted=%b",
               tag, $time, CHIME_OUT, ACTIVE_PRI, MUTED, c, p, m);
    end
  endtask

  // Scoreboard: one expectation per clock edge, checked just after the edge.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compare(e.tag, e.c, e.p, e.m);
    end
  end

  task automatic expect_next(input int tag, input logic c, input logic [1:0] p, input logic m);
    exp_t e;
    e.tag = tag;
    e.c   = c;
    e.p   = p;
    e.m   = m;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic k, input logic w1, input logic w2, input logic ak,
                      input int tag, input logic c, input logic [1:0] p, input logic m);
    @(negedge CLK);
    KEY       = k;
    WARN_PRI1 = w1;
    WARN_PRI2 = w2;
    ACK       = ak;
    expect_next(tag, c, p, m);
  endtask

  task automatic run(input logic k, input logic w1, input logic w2, input logic ak, input int n,
                     input int tag, input logic c, input logic [1:0] p, input logic m);
    for (int i = 0; i < n; i++) step(k, w1, w2, ak, tag, c, p, m);
  endtask

  task automatic add(input logic k, input logic w1, input logic w2, input logic ak, input int n,
                     input logic c, input logic [1:0] p, input logic m, input int tag);
    vec_t v;
    v.k = k; v.w1 = w1; v.w2 = w2; v.ak = ak; v.n = n;
    v.c = c; v.p = p; v.m = m; v.tag = tag;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   pos;
    logic on_c;
    logic hold_c;

    #3;
    compare(0, 1'b0, NONE, 1'b0);

    // Idle, then PRI2 held: three 4/12 bursts, mute, ACK ignored in HOLD, release.
    add(1,0,0,0, 2, 0,NONE,0, 1);
    for (int b = 0; b < P2_REPS; b++) begin
      add(1,0,1,0, 4,  1,P2,0, 2);
      add(1,0,1,0, 12, 0,P2,0, 2);
    end
    add(1,0,1,0, 6, 0,P2,1, 2);
    add(1,0,1,1, 1, 0,P2,1, 2);
    add(1,0,1,0, 3, 0,P2,1, 2);
    add(1,0,0,0, 2, 0,NONE,0, 2);
    // PRI1 held: 8/8 pattern with ACK pulses that must not disturb it.
    add(1,1,0,0, 3, 1,P1,0, 3);
    add(1,1,0,1, 1, 1,P1,0, 3);
    add(1,1,0,0, 4, 1,P1,0, 3);
    add(1,1,0,0, 2, 0,P1,0, 3);
    add(1,1,0,1, 1, 0,P1,0, 3);
    add(1,1,0,0, 5, 0,P1,0, 3);
    add(1,1,0,0, 8, 1,P1,0, 3);
    add(1,1,0,0, 8, 0,P1,0, 3);
    add(1,1,0,0, 3, 1,P1,0, 3);
    // PRI1 falls to PRI2, PRI1 preempts mid-P2_OFF, KEY drop mid-P1_ON.
    add(1,0,1,0, 4, 1,P2,0, 4);
    add(1,0,1,0, 6, 0,P2,0, 4);
    add(1,1,1,0, 5, 1,P1,0, 4);
    add(0,1,1,0, 1, 0,NONE,0, 4);
    add(0,1,1,0, 2, 0,NONE,0, 4);
    add(1,0,0,0, 2, 0,NONE,0, 4);

    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      run(vecs[i].k, vecs[i].w1, vecs[i].w2, vecs[i].ak, vecs[i].n,
          vecs[i].tag, vecs[i].c, vecs[i].p, vecs[i].m);

    // PRI1 rises together with an ACK edge in P2_OFF, then PRI2 resumes with a fresh budget.
    run(1,0,1,0, 4,  5, 1,P2,0);
    run(1,0,1,0, 12, 5, 0,P2,0);
    run(1,0,1,0, 4,  5, 1,P2,0);
    run(1,0,1,0, 5,  5, 0,P2,0);
    run(1,1,1,1, 4,  5, 1,P1,0);
    for (int b = 0; b < P2_REPS; b++) begin
      run(1,0,1,0, 4,  5, 1,P2,0);
      run(1,0,1,0, 12, 5, 0,P2,0);
    end
    run(1,0,1,0, 3, 5, 0,P2,1);
    run(1,0,0,0, 1, 5, 0,NONE,0);

    // ACK rises in the second P2_ON cycle and stays high for 20 cycles.
    for (int e = 1; e <= 22; e++) begin
      pos    = (e - 1) % 16;
      on_c   = (pos < 4);
      hold_c = ACK_EN && (e >= 3);
      step(1, 0, 1, (e >= 3), 6, hold_c ? 1'b0 : on_c, P2, hold_c);
    end
    run(1,0,0,0, 2, 6, 0,NONE,0);

    // Asynchronous reset mid-P2_ON, then a full-length restart.
    run(1,0,1,0, 2, 7, 1,P2,0);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    compare(7, 1'b0, NONE, 1'b0);
    @(posedge CLK);
    #1;
    compare(7, 1'b0, NONE, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    expect_next(7, 1'b1, P2, 1'b0);
    run(1,0,1,0, 3,  7, 1,P2,0);
    run(1,0,1,0, 12, 7, 0,P2,0);
    run(1,0,1,0, 1,  7, 1,P2,0);
    run(1,0,0,0, 2,  8, 0,NONE,0);

    @(posedge CLK);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
